// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: hits return in the same cycle;
// a miss stalls the fetch stage and fills the whole line in order over req/ack.
module instr_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int LB = WB + 2;
    localparam int TB = 32 - LB - IB;

    typedef enum logic {IDLE, FILL} state_t;

    state_t         state_reg;
    logic [LINES-1:0] valid_reg;
    logic [TB-1:0]  tag_mem  [LINES];
    logic [31:0]    data_mem [LINES*WORDS];
    logic [31:0]    fill_base_reg;
    logic [WB-1:0]  fill_cnt_reg;

    logic [WB-1:0]  word_sel;
    logic [IB-1:0]  index_sel;
    logic [TB-1:0]  tag_sel;
    logic [31:0]    line_base;
    logic [IB-1:0]  fill_idx;
    logic [TB-1:0]  fill_tag;
    logic [WB-1:0]  next_cnt;
    logic           hit;
    logic           fill_ack;
    logic           fill_last;
    logic           unused_offset;

    assign word_sel      = instr_addr[2 +: WB];
    assign index_sel     = instr_addr[LB +: IB];
    assign tag_sel       = instr_addr[31 -: TB];
    assign line_base     = {instr_addr[31:LB], {LB{1'b0}}};
    assign unused_offset = ^instr_addr[1:0];

    assign fill_idx  = fill_base_reg[LB +: IB];
    assign fill_tag  = fill_base_reg[31 -: TB];
    assign next_cnt  = fill_cnt_reg + WB'(1);
    assign fill_last = (fill_cnt_reg == WB'(WORDS - 1));
    assign fill_ack  = (state_reg == FILL) && mem_req && mem_ack;

    assign hit   = valid_reg[index_sel] && (tag_mem[index_sel] == tag_sel);
    assign stall = (state_reg != IDLE) || !hit;
    assign instr = stall ? 32'h0000_0000 : data_mem[{index_sel, word_sel}];

    // Data and tag arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (rst && fill_ack) begin
            data_mem[{fill_idx, fill_cnt_reg}] <= mem_data;
            if (fill_last) begin
                tag_mem[fill_idx] <= fill_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            valid_reg     <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= 32'h0000_0000;
            fill_base_reg <= 32'h0000_0000;
            fill_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!hit) begin
                        // Invalidate up front so an aborted fill never looks valid.
                        valid_reg[index_sel] <= 1'b0;
                        fill_base_reg        <= line_base;
                        fill_cnt_reg         <= '0;
                        mem_req              <= 1'b1;
                        mem_addr             <= line_base;
                        state_reg            <= FILL;
                    end
                end
                FILL: begin
                    if (fill_ack) begin
                        fill_cnt_reg <= next_cnt;
                        if (fill_last) begin
                            valid_reg[fill_idx] <= 1'b1;
                            mem_req             <= 1'b0;
                            state_reg           <= IDLE;
                        end else begin
                            mem_addr <= fill_base_reg | {{(32-LB){1'b0}}, next_cnt, 2'b00};
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache with a backing-memory responder that has
// a programmable number of wait cycles per request.
module tb_instr_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_addr = 32'h0;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = 32'h0;

    int n_total = 0;
    int n_bad   = 0;

    int          wait_cfg = 0;
    logic        stray_ack = 1'b0;
    int          wcnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          req_rises = 0;
    int          hold_err = 0;
    logic [31:0] ack_log[$];

    instr_cache #(.LINES(16), .WORDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_addr (instr_addr),
        .instr      (instr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hDEAD0000 | {16'h0000, a[15:0]};
    endfunction

    // Responder: decides at the falling edge what the next rising edge samples.
    always @(negedge clk) begin
        if (prev_req && !prev_ack && mem_req && mem_addr != prev_addr)
            hold_err = hold_err + 1;
        if (!mem_req || prev_ack || !prev_req) wcnt = 0;
        else wcnt = wcnt + 1;
        if (mem_req && !prev_req) req_rises = req_rises + 1;
        mem_ack  = (mem_req && wcnt == wait_cfg) || stray_ack;
        mem_data = mem_word(mem_addr);
        if (mem_req && mem_ack) ack_log.push_back(mem_addr);
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an address and wait (bounded) until it hits; NOP checked each stall cycle.
    task automatic fetch(input logic [31:0] a, output int nstall, output int nop_bad);
        nstall  = 0;
        nop_bad = 0;
        instr_addr = a;
        #1;
        while (stall && nstall < 100) begin
            if (instr !== 32'h0) nop_bad++;
            nstall++;
            step();
        end
    endtask

    task automatic check_fill(input string tag, input logic [31:0] base);
        check_val({tag, "_nacks"}, 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_log.size())
                check_val($sformatf("%s_addr%0d", tag, i), ack_log[i], base + 32'(4*i));
        end
    endtask

    initial begin
        int ns;
        int nb;
        int rises0;

        repeat (3) step();
        check_val("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_stall", {31'h0, stall}, 32'h1);
        rst = 1'b1;

        // Cold miss
        ack_log.delete();
        fetch(32'h10, ns, nb);
        check_val("cold_stall_cycles", 32'(ns), 32'd5);
        check_val("cold_nop", 32'(nb), 32'd0);
        check_val("cold_instr", instr, 32'hDEAD0010);
        check_fill("cold", 32'h10);

        // Line hits
        for (int i = 1; i < 4; i++) begin
            step();
            instr_addr = 32'h10 + 32'(4*i);
            #1;
            check_val($sformatf("hit%0d_stall", i), {31'h0, stall}, 32'h0);
            check_val($sformatf("hit%0d_instr", i), instr, 32'hDEAD0010 + 32'(4*i));
            check_val($sformatf("hit%0d_req", i), {31'h0, mem_req}, 32'h0);
        end

        // Stray ack while idle is ignored
        step();
        instr_addr = 32'h10;
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        #1;
        check_val("stray_req", {31'h0, mem_req}, 32'h0);
        check_val("stray_stall", {31'h0, stall}, 32'h0);
        check_val("stray_instr", instr, 32'hDEAD0010);

        // Conflict eviction
        step();
        rises0 = req_rises;
        ack_log.delete();
        fetch(32'h000, ns, nb);
        check_val("conf0_stall_cycles", 32'(ns), 32'd5);
        check_val("conf0_instr", instr, 32'hDEAD0000);
        check_fill("conf0", 32'h000);
        step();
        ack_log.delete();
        fetch(32'h100, ns, nb);
        check_val("conf1_stall_cycles", 32'(ns), 32'd5);
        check_val("conf1_instr", instr, 32'hDEAD0100);
        check_fill("conf1", 32'h100);
        check_val("conf_req_rises", 32'(req_rises - rises0), 32'd2);
        step();
        fetch(32'h000, ns, nb);
        check_val("conf_refill_cycles", 32'(ns), 32'd5);
        check_val("conf_refill_instr", instr, 32'hDEAD0000);

        // Wait states
        step();
        wait_cfg = 2;
        hold_err = 0;
        ack_log.delete();
        fetch(32'h40, ns, nb);
        check_val("wait_stall_cycles", 32'(ns), 32'd13);
        check_val("wait_nop", 32'(nb), 32'd0);
        check_val("wait_instr", instr, 32'hDEAD0040);
        check_val("wait_addr_hold", 32'(hold_err), 32'd0);
        check_fill("wait", 32'h40);
        wait_cfg = 0;

        // Address change mid-fill
        step();
        ack_log.delete();
        instr_addr = 32'h20;
        #1;
        check_val("chg_first_stall", {31'h0, stall}, 32'h1);
        step();
        step();
        fetch(32'h80, ns, nb);
        check_val("chg_stall_cycles", 32'(ns), 32'd8);
        check_val("chg_instr", instr, 32'hDEAD0080);
        check_val("chg_nacks", 32'(ack_log.size()), 32'd8);
        if (ack_log.size() == 8) begin
            check_val("chg_addr0", ack_log[0], 32'h20);
            check_val("chg_addr3", ack_log[3], 32'h2C);
            check_val("chg_addr4", ack_log[4], 32'h80);
            check_val("chg_addr7", ack_log[7], 32'h8C);
        end
        step();
        fetch(32'h20, ns, nb);
        check_val("chg_rehit_cycles", 32'(ns), 32'd0);
        check_val("chg_rehit_instr", instr, 32'hDEAD0020);

        // Reset mid-fill
        step();
        ack_log.delete();
        instr_addr = 32'h30;
        for (int i = 0; i < 20 && ack_log.size() < 2; i++) step();
        check_val("rmf_acks_before", 32'(ack_log.size()), 32'd2);
        rst = 1'b0;
        step();
        check_val("rmf_req_dropped", {31'h0, mem_req}, 32'h0);
        check_val("rmf_stall", {31'h0, stall}, 32'h1);
        rst = 1'b1;
        ack_log.delete();
        fetch(32'h30, ns, nb);
        check_val("rmf_stall_cycles", 32'(ns), 32'd5);
        check_val("rmf_instr", instr, 32'hDEAD0030);
        check_fill("rmf", 32'h30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the CPU's fetch port (`instr_addr`/`instr`) and a slower backing instruction memory. Hits return the instruction in the same cycle. Misses assert `stall` and fill the whole line from backing memory, one word at a time, over a req/ack handshake. The CPU's fetch stage holds the PC and the fetch/decode register while `stall` is high.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; power of two, at least 2.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `instr_addr`  in  32  fetch byte address from the PC; bits [1:0] are ignored.
- `instr`  out  32  the instruction at `instr_addr`; 32'h00000000 (NOP) whenever `stall`=1.
- `stall`  out  1  1 when `instr` is not valid this cycle (a miss or a fill in progress).
- `mem_req`  out  1  read request to backing memory; registered.
- `mem_addr`  out  32  word-aligned read address; registered, stable while `mem_req`=1.
- `mem_ack`  in  1  backing memory has valid data this cycle; sampled only while `mem_req`=1.
- `mem_data`  in  32  read data, valid when `mem_ack`=1.

## Operation
- Address split: offset = [1:0] (ignored); word = next log2(WORDS) bits; index = next log2(LINES) bits; tag = the remaining upper bits. With the defaults: word [3:2], index [7:4], tag [31:8].
- Storage per line: a valid bit, a tag, and WORDS data words.
- Hit = valid[index] && tag[index]==tag. This is combinational from `instr_addr`.
- FSM states:
  - IDLE:
    - On hit: `stall`=0 and `instr`=data[index][word].
    - On miss: `stall`=1. Latch the line base address (instr_addr with word and offset bits zeroed) into `fill_base`. Clear `fill_cnt`. Go to FILL.
  - FILL:
    - `stall`=1. `mem_req`=1 and `mem_addr` = fill_base + 4*fill_cnt.
    - On `mem_ack`: write `mem_data` into data[fill index][fill_cnt] and increment `fill_cnt`. `mem_req` stays high into the next word with no idle cycle.
    - On the ack for word WORDS-1: write tag, set valid, drop `mem_req`, go to IDLE.
- Words are always filled in order 0..WORDS-1 (no critical-word-first).
- Only one request is outstanding at a time. `mem_addr` changes only in the cycle after an ack.
- A fill always completes for the latched `fill_base`, even if `instr_addr` changes mid-fill. After the fill, IDLE re-evaluates the current `instr_addr`.
- The target line's valid bit is cleared when the fill starts. A reset mid-fill therefore never leaves a partially filled line marked valid.

## Timing
- Reset (rst=0 at an edge) gives: all valid bits 0, state IDLE, `mem_req`=0, `mem_addr`=0, `fill_cnt`=0.
  - `stall` is combinational. It therefore reads 1 for any address after reset, because every lookup misses.
  - Data and tag arrays are not reset.
- Reset asserted mid-fill aborts the fill. `mem_req` is 0 from the next cycle; any `mem_ack` after that is ignored.
- Hit latency: 0 cycles. `instr` is valid in the cycle `instr_addr` is presented.
- Miss penalty with zero-wait memory (ack in the same cycle as req):
  - Cycle 0: miss detected in IDLE.
  - Cycles 1..WORDS: FILL, one word per cycle.
  - Cycle WORDS+1: IDLE hit.
  - `stall` is high for WORDS+1 cycles (5 with the defaults).
- Each extra wait cycle of `mem_ack` adds one stall cycle.
- `mem_ack` while `mem_req`=0 is ignored.
- Lines are overwritten on conflict; no replacement state is needed.

## Test plan
- **Cold miss:** after reset, `instr_addr`=0x00000010.
  - `stall`=1 and `instr`=0 for 5 cycles.
  - `mem_addr` sequence 0x10, 0x14, 0x18, 0x1C.
  - Then `stall`=0 and `instr`=mem[0x10].
- **Line hit:** after that fill, `instr_addr`=0x14, 0x18, 0x1C on consecutive cycles.
  - `stall`=0 every cycle; `instr` = the matching memory words.
  - `mem_req` stays 0.
- **Conflict eviction:**
  - Fill 0x000 and then 0x100 (same index, different tag); `mem_req` is seen twice.
  - Fetching 0x000 again misses and refills.
- **Wait states:** memory acks 2 cycles after each request on the 0x40 fill.
  - `stall` is high 13 cycles.
  - `mem_addr` holds each value until its ack.
- **Address change mid-fill:** miss on 0x20, then `instr_addr` changes to 0x80 during FILL.
  - The fill completes at 0x20..0x2C.
  - A second fill at 0x80..0x8C follows.
  - Afterwards 0x20 hits.
- **Reset mid-fill:** rst=0 after 2 acks on the 0x30 fill.
  - `mem_req`=0 the next cycle.
  - After release, 0x30 misses and refetches all 4 words.
